// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output start, op, busA, busB, flush,
    input  hi, lo, busy
  );

  modport slave (
    input  start, op, busA, busB, flush,
    output hi, lo, busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply (shift-add) / restoring divide engine producing HI/LO and a stall.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise every op is unsigned.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic        clk,
  input logic        reset,
  ex_muldiv_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_q, div_d;

  logic               launch;
  logic               last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shl, div_trial;
  logic [WIDTH-1:0]   step_acc, step_sh;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign launch = (state_q == StIdle) && bus.start && !bus.flush;
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
  logic                 a_neg, b_neg;
  logic                 neg_res_q, neg_rem_q, dz_q;
  logic [2*WIDTH-1:0]   prod, prod_fix;

  assign a_neg = bus.op[0] & bus.busA[WIDTH-1];
  assign b_neg = bus.op[0] & bus.busB[WIDTH-1];
  assign a_mag = a_neg ? -bus.busA : bus.busA;
  assign b_mag = b_neg ? -bus.busB : bus.busB;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else if (launch) begin
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      dz_q      <= (bus.busB == '0);
    end
  end

  assign prod     = {step_acc, step_sh};
  assign prod_fix = neg_res_q ? -prod : prod;

  // Divide by zero: quotient forced to all ones; sign-fixed remainder equals the raw dividend.
  always_comb begin
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo = prod_fix[WIDTH-1:0];
    if (div_q) begin
      fin_hi = neg_rem_q ? -step_acc : step_acc;
      fin_lo = dz_q ? '1 : (neg_res_q ? -step_sh : step_sh);
    end
  end
`else
  logic unused_op0;
  assign unused_op0 = bus.op[0];
  assign a_mag      = bus.busA;
  assign b_mag      = bus.busB;
  // With a zero divisor every trial subtract succeeds, so quotient=all ones, remainder=dividend.
  assign fin_hi     = step_acc;
  assign fin_lo     = step_sh;
`endif

  // Shared step: acc holds the running HI/remainder, sh the multiplier or dividend/quotient.
  assign mul_sum   = {1'b0, acc_q} + {1'b0, (sh_q[0] ? m_q : {WIDTH{1'b0}})};
  assign div_shl   = {acc_q, sh_q[WIDTH-1]};
  assign div_trial = div_shl - {1'b0, m_q};

  always_comb begin
    step_acc = mul_sum[WIDTH:1];
    step_sh  = {mul_sum[0], sh_q[WIDTH-1:1]};
    if (div_q) begin
      if (!div_trial[WIDTH]) begin
        step_acc = div_trial[WIDTH-1:0];
        step_sh  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_shl[WIDTH-1:0];
        step_sh  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // FSM state register
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush wins over completion
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch) state_d = StRun;
      StRun:   if (bus.flush || last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy = reset && (bus.start || (state_q == StRun));
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    sh_d  = sh_q;
    m_d   = m_q;
    div_d = div_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (launch) begin
      cnt_d = '0;
      acc_d = '0;
      div_d = bus.op[1];
      m_d   = bus.op[1] ? b_mag : a_mag;
      sh_d  = bus.op[1] ? a_mag : b_mag;
    end else if ((state_q == StRun) && !bus.flush) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = step_acc;
      sh_d  = step_sh;
      if (last) begin
        hi_d = fin_hi;
        lo_d = fin_lo;
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      sh_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sh_q  <= sh_d;
      m_q   <= m_d;
      div_q <= div_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus queues expected HI/LO and busy length,
// a monitor pops and compares whenever busy drops.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(W)) mif ();

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mif)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           len;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: samples mid-cycle, between the posedge drive and the negedge update.
  initial begin : monitor
    int   len;
    logic prev;
    exp_t e;
    len  = 0;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (mif.busy === 1'b1) begin
        len++;
      end else begin
        if (prev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_busy_drop: got len %0d want no activity", len);
          end else begin
            e = sb.pop_front();
            chk({e.tag, "_hi"}, 64'(mif.hi), 64'(e.hi));
            chk({e.tag, "_lo"}, 64'(mif.lo), 64'(e.lo));
            chk({e.tag, "_busy_len"}, 64'(len), 64'(e.len));
          end
        end
        len = 0;
      end
      prev = (mif.busy === 1'b1);
    end
  end

  // Issue one op; flush/rogue-start/reset cycles are relative to the start cycle (-1 = none).
  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int flush_cyc, input int rogue_cyc, input int rst_cyc);
    exp_t e;
    @(posedge clk);
    #1;
    mif.start = 1'b1;
    mif.op    = op;
    mif.busA  = a;
    mif.busB  = b;
    mif.flush = (flush_cyc == 0);
    if (flush_cyc >= 0)    e = '{tag, cur_hi, cur_lo, flush_cyc + 1};
    else if (rst_cyc >= 0) e = '{tag, '0, '0, rst_cyc};
    else                   e = '{tag, eh, el, 33};
    sb.push_back(e);
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk);
      #1;
      mif.start = (c == rogue_cyc);
      mif.op    = (c == rogue_cyc) ? 2'b00 : op;
      mif.busA  = ~a;
      mif.busB  = ~b;
      mif.flush = (c == flush_cyc);
      reset     = (c != rst_cyc);
    end
    mif.start = 1'b0;
    mif.flush = 1'b0;
    reset     = 1'b1;
    cur_hi    = e.hi;
    cur_lo    = e.lo;
  endtask

  initial begin : stim
    reset     = 1'b0;
    mif.start = 1'b0;
    mif.op    = 2'b00;
    mif.busA  = '0;
    mif.busB  = '0;
    mif.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", 64'(mif.hi), 64'h0);
    chk("reset_lo", 64'(mif.lo), 64'h0);
    mif.start = 1'b1;
    #1;
    chk("reset_busy_forced_low", 64'(mif.busy), 64'h0);
    mif.start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1, -1, -1);
`ifdef MULDIV_SIGNED_EN
    do_op("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, -1, -1, -1);
`else
    do_op("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, -1, -1, -1);
`endif
    do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, -1, -1, -1);
`ifdef MULDIV_SIGNED_EN
    do_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1, -1, -1);
    do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, -1, -1, -1);
`else
    do_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC, -1, -1, -1);
    do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, -1, -1, -1);
`endif
    do_op("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, -1, -1, -1);
    do_op("div_neg_by0", 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, -1, -1, -1);
    do_op("flush_c10", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 10, -1, -1);
    do_op("multu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, -1, -1, -1);
    do_op("flush_last", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32, -1, -1);
    do_op("flush_idle", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 0, -1, -1);
    do_op("start_in_run", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, -1, 5, -1);
    do_op("reset_mid", 2'b10, 32'hFFFFFFFF, 32'd3, 32'd0, 32'h55555555, -1, -1, 15);
    do_op("mult_min_sq", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, -1, -1, -1);
    do_op("div_pos", 2'b11, 32'h12345678, 32'h00001000, 32'h00000678, 32'h00012345, -1, -1, -1);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
